// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low digit patterns, blank code,
// decode result payload and the reader's sequence-tracking state encoding.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } seg_state_e;

  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] value;
  } seg_dec_t;

  // Successor digit in the up-counter sequence, 9 wraps to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern classifier: digit value, blank, or invalid.
module seg_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output seg_dec_t         dec_o
);

  always_comb begin
    dec_o.is_digit = 1'b1;
    dec_o.is_blank = 1'b0;
    dec_o.value    = 4'd0;
    case (pattern_i)
      SEG_0:     dec_o.value = 4'd0;
      SEG_1:     dec_o.value = 4'd1;
      SEG_2:     dec_o.value = 4'd2;
      SEG_3:     dec_o.value = 4'd3;
      SEG_4:     dec_o.value = 4'd4;
      SEG_5:     dec_o.value = 4'd5;
      SEG_6:     dec_o.value = 4'd6;
      SEG_7:     dec_o.value = 4'd7;
      SEG_8:     dec_o.value = 4'd8;
      SEG_9:     dec_o.value = 4'd9;
      SEG_BLANK: begin
        dec_o.is_digit = 1'b0;
        dec_o.is_blank = 1'b1;
      end
      default:   dec_o.is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Reads an asynchronous seven-segment bus, debounces it and reports digits/errors.
// Define SEG_READER_SEQ_CHECK_EN to enable up-count sequence checking.
module seg_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       display,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0] sync1_q, sync2_q, sample_q, last_acc_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, blank_q, blank_d, seq_err_q;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  seg_dec_t dec;
  logic     accept_c, digit_acc_c, blank_acc_c, invalid_acc_c;
  logic     seq_viol_c, err_c;

  seg_pattern_decode u_decode (
    .pattern_i (sample_q),
    .dec_o     (dec)
  );

  // Stability counter: clears on change, saturates once qualified.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (sync2_q != sample_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end
  end

  // Accept only on the qualifying cycle and only a pattern new since last acceptance.
  always_comb begin
    accept_c      = (stab_cnt_d == STABLE_MAX) && (stab_cnt_q != STABLE_MAX) &&
                    (sample_q != last_acc_q);
    digit_acc_c   = accept_c && dec.is_digit;
    blank_acc_c   = accept_c && dec.is_blank;
    invalid_acc_c = accept_c && !dec.is_digit && !dec.is_blank;
  end

`ifdef SEG_READER_SEQ_CHECK_EN
  seg_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (invalid_acc_c) begin
      state_d = ST_IDLE;
    end else if (digit_acc_c) begin
      state_d = ST_TRACK;
    end
  end

  // digit_q holds the reference digit while tracking.
  always_comb begin
    seq_viol_c = 1'b0;
    if ((state_q == ST_TRACK) && digit_acc_c && (dec.value != next_digit(digit_q))) begin
      seq_viol_c = 1'b1;
    end
  end
`else
  always_comb begin
    seq_viol_c = 1'b0;
  end
`endif

  always_comb begin
    err_c   = invalid_acc_c || seq_viol_c;
    digit_d = digit_q;
    blank_d = blank_q;
    if (digit_acc_c) begin
      digit_d = dec.value;
      blank_d = 1'b0;
    end else if (blank_acc_c) begin
      blank_d = 1'b1;
    end
    err_count_d = err_count_q;
    if (err_c && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= SEG_BLANK;
      sync2_q       <= SEG_BLANK;
      sample_q      <= SEG_BLANK;
      last_acc_q    <= SEG_BLANK;
      stab_cnt_q    <= '0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b1;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      sync1_q       <= display;
      sync2_q       <= sync1_q;
      sample_q      <= sync2_q;
      stab_cnt_q    <= stab_cnt_d;
      if (accept_c) begin
        last_acc_q  <= sample_q;
      end
      digit_q       <= digit_d;
      digit_valid_q <= digit_acc_c;
      blank_q       <= blank_d;
      seq_err_q     <= err_c;
      err_count_q   <= err_count_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule
